// File: rtl/sd_emmc_adma2_pkg.sv
// Shared ADMA2 encodings: descriptor actions, error-state codes, descriptor bit
// positions and the sequencer state type.
package sd_emmc_adma2_pkg;

   localparam logic [1:0] ACT_NOP  = 2'b00;
   localparam logic [1:0] ACT_RSV  = 2'b01;
   localparam logic [1:0] ACT_TRAN = 2'b10;
   localparam logic [1:0] ACT_LINK = 2'b11;

   localparam logic [1:0] ST_STOP = 2'b00;
   localparam logic [1:0] ST_FDS  = 2'b01;
   localparam logic [1:0] ST_TFR  = 2'b11;

   localparam int DESC_LEN_HI = 31;
   localparam int DESC_LEN_LO = 16;
   localparam int DESC_ACT_HI = 5;
   localparam int DESC_ACT_LO = 4;
   localparam int DESC_INT    = 2;
   localparam int DESC_END    = 1;
   localparam int DESC_VALID  = 0;

   localparam logic [31:0] DESC_BYTES = 32'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_AR,
      S_FETCH_R,
      S_DECODE,
      S_XFER_START,
      S_XFER_WAIT,
      S_NEXT,
      S_ERROR
   } adma_state_e;

   // A zero length field encodes the full 64 KiB segment.
   function automatic logic [16:0] desc_len(input logic [15:0] len);
      return {len == 16'd0, len};
   endfunction

endpackage

// File: rtl/sd_emmc_adma2_desc_fetch.sv
// Two-beat descriptor fetch: AR/R handshakes, saturating fetch timeout and
// word0/word1 capture. Phases are driven by the sequencer state.
module sd_emmc_adma2_desc_fetch
   import sd_emmc_adma2_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ar_phase,
   input  logic        r_phase,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   input  logic        axi_rlast,
   output logic        ar_done,
   output logic        desc_valid,
   output logic        fetch_err,
   output logic [31:0] word0,
   output logic [31:0] word1
);

   localparam int TW = $clog2(FETCH_TIMEOUT + 1);

   logic [TW-1:0] tmo_cnt;
   logic          second_beat;
   logic          expired;
   logic          r_fire;
   logic          beat_bad;

   // Valid/ready: a beat moves on any cycle where both are high; arvalid and
   // rready are held for the whole phase and never depend on the ready/valid.
   assign axi_arvalid = ar_phase;
   assign axi_rready  = r_phase;
   assign ar_done     = ar_phase && axi_arready;

   assign expired    = (tmo_cnt >= TW'(FETCH_TIMEOUT - 1));
   assign r_fire     = r_phase && axi_rvalid;
   assign beat_bad   = r_fire && ((axi_rresp != 2'b00) || (axi_rlast != second_beat));
   assign desc_valid = r_fire && second_beat && !beat_bad;
   assign fetch_err  = beat_bad ||
                       (expired && ((ar_phase && !ar_done) || (r_phase && !desc_valid)));

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt     <= '0;
         second_beat <= 1'b0;
         word0       <= '0;
         word1       <= '0;
      end else begin
         if (ar_phase || r_phase) begin
            if (tmo_cnt != TW'(FETCH_TIMEOUT))
               tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         second_beat <= r_phase && (second_beat || r_fire);
         if (r_fire && !second_beat)
            word0 <= axi_rdata;
         if (r_fire && second_beat)
            word1 <= axi_rdata;
      end
   end

endmodule

// File: rtl/sd_emmc_adma2_sequencer.sv
// ADMA2 descriptor table walker feeding the DMA engine. Optional macro
// SD_ADMA_DESC_INT_EN enables the per-descriptor desc_int pulse.
module sd_emmc_adma2_sequencer
   import sd_emmc_adma2_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 1024,
   parameter int MAX_LINKS     = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        adma_start,
   input  logic        adma_abort,
   input  logic [31:0] desc_base_addr,
   output logic [31:0] axi_araddr,
   output logic [7:0]  axi_arlen,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   input  logic        axi_rlast,
   output logic [31:0] xfer_addr,
   output logic [16:0] xfer_len,
   output logic        xfer_start,
   input  logic        xfer_done,
   input  logic        xfer_err,
   output logic [31:0] adma_sys_addr,
   output logic [1:0]  adma_err_state,
   output logic        adma_err_int,
   output logic        adma_done,
   output logic        desc_int,
   output logic        busy
);

   localparam int LW = $clog2(MAX_LINKS + 1);

   adma_state_e state, state_nxt;
   logic [LW-1:0] link_cnt, link_nxt;
   logic [31:0]   sys_addr_nxt, xaddr_nxt;
   logic [16:0]   xlen_nxt;
   logic [1:0]    est_nxt;
   logic          eint_nxt, last_tran, tran_nxt;
   logic          ar_done, desc_valid, fetch_err, int_flag;
   logic [31:0]   word0, word1;
   logic [1:0]    act;
   logic          unused_bits;

   sd_emmc_adma2_desc_fetch #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_fetch (
      .clock       (clock),
      .reset       (reset),
      .ar_phase    (state == S_FETCH_AR),
      .r_phase     (state == S_FETCH_R),
      .axi_arvalid (axi_arvalid),
      .axi_arready (axi_arready),
      .axi_rdata   (axi_rdata),
      .axi_rresp   (axi_rresp),
      .axi_rvalid  (axi_rvalid),
      .axi_rready  (axi_rready),
      .axi_rlast   (axi_rlast),
      .ar_done     (ar_done),
      .desc_valid  (desc_valid),
      .fetch_err   (fetch_err),
      .word0       (word0),
      .word1       (word1)
   );

   assign axi_araddr = adma_sys_addr;
   assign axi_arlen  = 8'd1;
   assign busy       = (state != S_IDLE);
   assign act        = word0[DESC_ACT_HI:DESC_ACT_LO];

`ifdef SD_ADMA_DESC_INT_EN
   assign int_flag    = word0[DESC_INT];
   assign unused_bits = ^{word0[15:6], word0[3]};
`else
   assign int_flag    = 1'b0;
   assign unused_bits = ^{word0[15:6], word0[3], word0[DESC_INT]};
`endif

   always_comb begin
      state_nxt    = state;
      link_nxt     = link_cnt;
      sys_addr_nxt = adma_sys_addr;
      xaddr_nxt    = xfer_addr;
      xlen_nxt     = xfer_len;
      est_nxt      = adma_err_state;
      eint_nxt     = adma_err_int;
      tran_nxt     = last_tran;
      xfer_start   = 1'b0;
      adma_done    = 1'b0;
      desc_int     = 1'b0;
      case (state)
         S_IDLE, S_ERROR: begin
            if (adma_start) begin
               sys_addr_nxt = desc_base_addr;
               link_nxt     = '0;
               eint_nxt     = 1'b0;
               est_nxt      = ST_STOP;
               state_nxt    = S_FETCH_AR;
               if (desc_base_addr[2:0] != 3'b000) begin
                  state_nxt = S_ERROR;
                  eint_nxt  = 1'b1;
                  est_nxt   = ST_FDS;
               end
            end
         end
         S_FETCH_AR: begin
            if (ar_done) begin
               state_nxt = S_FETCH_R;
            end else if (adma_abort) begin
               state_nxt = S_IDLE;
            end else if (fetch_err) begin
               state_nxt = S_ERROR;
               eint_nxt  = 1'b1;
               est_nxt   = ST_FDS;
            end
         end
         // Abort is not sampled here; the burst drains and DECODE honours it.
         S_FETCH_R: begin
            if (fetch_err) begin
               state_nxt = S_ERROR;
               eint_nxt  = 1'b1;
               est_nxt   = ST_FDS;
            end else if (desc_valid) begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (adma_abort) begin
               state_nxt = S_IDLE;
            end else if (!word0[DESC_VALID]) begin
               state_nxt = S_ERROR;
               eint_nxt  = 1'b1;
               est_nxt   = ST_FDS;
            end else if (act == ACT_TRAN) begin
               xaddr_nxt = word1;
               xlen_nxt  = desc_len(word0[DESC_LEN_HI:DESC_LEN_LO]);
               tran_nxt  = 1'b1;
               state_nxt = S_XFER_START;
            end else if (link_cnt == LW'(MAX_LINKS - 1)) begin
               state_nxt = S_ERROR;
               eint_nxt  = 1'b1;
               est_nxt   = ST_FDS;
            end else begin
               link_nxt = link_cnt + 1'b1;
               tran_nxt = 1'b0;
               if (act == ACT_LINK) begin
                  sys_addr_nxt = word1;
                  state_nxt    = word0[DESC_END] ? S_NEXT : S_FETCH_AR;
               end else begin
                  sys_addr_nxt = adma_sys_addr + DESC_BYTES;
                  state_nxt    = S_NEXT;
               end
            end
         end
         S_XFER_START: begin
            xfer_start = 1'b1;
            link_nxt   = '0;
            state_nxt  = S_XFER_WAIT;
         end
         S_XFER_WAIT: begin
            if (xfer_err) begin
               state_nxt = S_ERROR;
               eint_nxt  = 1'b1;
               est_nxt   = ST_TFR;
            end else if (xfer_done) begin
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (adma_abort) begin
               state_nxt = S_IDLE;
            end else begin
               desc_int = int_flag;
               if (word0[DESC_END]) begin
                  adma_done = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  if (last_tran)
                     sys_addr_nxt = adma_sys_addr + DESC_BYTES;
                  state_nxt = S_FETCH_AR;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         link_cnt       <= '0;
         adma_sys_addr  <= '0;
         xfer_addr      <= '0;
         xfer_len       <= '0;
         adma_err_state <= ST_STOP;
         adma_err_int   <= 1'b0;
         last_tran      <= 1'b0;
      end else begin
         state          <= state_nxt;
         link_cnt       <= link_nxt;
         adma_sys_addr  <= sys_addr_nxt;
         xfer_addr      <= xaddr_nxt;
         xfer_len       <= xlen_nxt;
         adma_err_state <= est_nxt;
         adma_err_int   <= eint_nxt;
         last_tran      <= tran_nxt;
      end
   end

endmodule

// File: tb/tb_sd_emmc_adma2_sequencer.sv
// Scoreboard bench for sd_emmc_adma2_sequencer: memory-backed AXI slave, DMA
// model, table-walk reference model. Honours SD_ADMA_DESC_INT_EN.
module tb_sd_emmc_adma2_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        adma_start, adma_abort;
   logic [31:0] desc_base_addr;
   logic [31:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic        axi_arvalid, axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid, axi_rready, axi_rlast;
   logic [31:0] xfer_addr;
   logic [16:0] xfer_len;
   logic        xfer_start, xfer_done, xfer_err;
   logic [31:0] adma_sys_addr;
   logic [1:0]  adma_err_state;
   logic        adma_err_int, adma_done, desc_int, busy;

   always #5 clock = ~clock;

   sd_emmc_adma2_sequencer dut (
      .clock(clock), .reset(reset), .adma_start(adma_start), .adma_abort(adma_abort),
      .desc_base_addr(desc_base_addr), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_rlast(axi_rlast), .xfer_addr(xfer_addr), .xfer_len(xfer_len),
      .xfer_start(xfer_start), .xfer_done(xfer_done), .xfer_err(xfer_err),
      .adma_sys_addr(adma_sys_addr), .adma_err_state(adma_err_state),
      .adma_err_int(adma_err_int), .adma_done(adma_done), .desc_int(desc_int), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_fetch_q[$];
   logic [48:0] exp_xfer_q[$];
   logic [31:0] mem [logic [31:0]];
   int done_cnt = 0, int_cnt = 0, seg_cnt = 0;
   int err_seg = -1, dma_delay = -1;
   bit ar_block = 1'b0;
   logic        exp_err_int, exp_done;
   logic [1:0]  exp_err_state;
   logic [31:0] exp_sys_addr;
   int          exp_int;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] mk(input logic [15:0] len, input logic [1:0] act,
                                      input logic i, input logic e, input logic v);
      return {len, 10'b0, act, 1'b0, i, e, v};
   endfunction

   task automatic put(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
      mem[a]     = w0;
      mem[a + 4] = w1;
   endtask

   // Reference: walk the table by the descriptor rules, recording every fetch,
   // every segment and how the walk ends.
   task automatic model_walk(input logic [31:0] base, input int e_seg);
      logic [31:0] a, w0, w1;
      logic [16:0] len;
      int links, seg, nint;
      exp_err_int = 0; exp_err_state = 2'b00; exp_done = 0; exp_sys_addr = base;
      a = base; links = 0; seg = 0; nint = 0;
      if (base[2:0] != 3'b000) begin
         exp_err_int = 1; exp_err_state = 2'b01;
      end else begin
         for (int step = 0; step < 64; step++) begin
            exp_fetch_q.push_back(a);
            w0 = rd(a); w1 = rd(a + 4); exp_sys_addr = a;
            if (!w0[0]) begin exp_err_int = 1; exp_err_state = 2'b01; break; end
            if (w0[5:4] == 2'b10) begin
               len = (w0[31:16] == 16'd0) ? 17'd65536 : {1'b0, w0[31:16]};
               exp_xfer_q.push_back({w1, len});
               links = 0;
               if (seg == e_seg) begin exp_err_int = 1; exp_err_state = 2'b11; break; end
               seg++;
               nint += int'(w0[2]);
               if (w0[1]) begin exp_done = 1; break; end
               a = a + 32'd8;
            end else begin
               links++;
               if (links == 16) begin exp_err_int = 1; exp_err_state = 2'b01; break; end
               a = (w0[5:4] == 2'b11) ? w1 : a + 32'd8;
               if (w0[1]) begin nint += int'(w0[2]); exp_sys_addr = a; exp_done = 1; break; end
               if (w0[5:4] != 2'b11) nint += int'(w0[2]);
            end
         end
      end
`ifdef SD_ADMA_DESC_INT_EN
      exp_int = nint;
`else
      exp_int = 0;
`endif
   endtask

   // Monitor: pops expectations whenever the DUT issues a fetch or a segment.
   always @(negedge clock) begin
      if (!reset) begin
         if (axi_arvalid && axi_arready) begin
            chk("arlen", {56'd0, axi_arlen}, 64'd1);
            if (exp_fetch_q.size() == 0) begin
               total++; bad++;
               $display("FAIL fetch_extra: got addr 0x%0h expected no fetch", axi_araddr);
            end else chk("fetch_addr", {32'd0, axi_araddr}, {32'd0, exp_fetch_q.pop_front()});
         end
         if (xfer_start) begin
            if (exp_xfer_q.size() == 0) begin
               total++; bad++;
               $display("FAIL xfer_extra: got 0x%0h/0x%0h expected no segment", xfer_addr, xfer_len);
            end else chk("xfer_addr_len", {15'd0, xfer_addr, xfer_len}, {15'd0, exp_xfer_q.pop_front()});
         end
         if (adma_done) done_cnt++;
         if (desc_int) int_cnt++;
      end
   end

   // AXI read slave backed by mem.
   initial begin
      logic [31:0] a;
      axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = 0; axi_rresp = 0;
      forever begin
         @(posedge clock); #1;
         axi_arready = !ar_block && ($urandom_range(0, 2) != 0);
         @(negedge clock);
         if (axi_arvalid && axi_arready) begin
            a = axi_araddr;
            @(posedge clock); #1;
            axi_arready = 0;
            for (int b = 0; b < 2; b++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
               axi_rvalid = 1;
               axi_rdata  = (b == 0) ? rd(a) : rd(a + 4);
               axi_rlast  = (b == 1);
               @(negedge clock);
               for (int k = 0; k < 3000 && !axi_rready; k++) @(negedge clock);
               @(posedge clock); #1;
               axi_rvalid = 0; axi_rlast = 0;
            end
         end
      end
   end

   // DMA engine model: completes each segment after a delay; err_seg fails.
   initial begin
      int seg, d;
      xfer_done = 0; xfer_err = 0;
      forever begin
         @(negedge clock);
         if (xfer_start) begin
            seg = seg_cnt;
            seg_cnt++;
            d = (dma_delay >= 0) ? dma_delay : $urandom_range(0, 20);
            repeat (d) @(posedge clock);
            @(posedge clock); #1;
            if (seg == err_seg) begin
               xfer_err  = 1;
               xfer_done = 1'($urandom_range(0, 1));
            end else xfer_done = 1;
            @(posedge clock); #1;
            xfer_done = 0; xfer_err = 0;
         end
      end
   end

   task automatic run_walk(input logic [31:0] base, input int e_seg, input bit abort_mid);
      bit fin;
      int done0, int0;
      fin = 0;
      exp_fetch_q.delete(); exp_xfer_q.delete();
      err_seg = (e_seg < 0) ? -1 : seg_cnt + e_seg;
      done0 = done_cnt; int0 = int_cnt;
      model_walk(base, e_seg);
      if (abort_mid) begin exp_done = 0; exp_int = 0; end
      @(posedge clock); #1;
      desc_base_addr = base; adma_start = 1;
      @(posedge clock); #1;
      adma_start = 0;
      if (abort_mid) begin
         for (int i = 0; i < 5000; i++) begin @(negedge clock); if (xfer_start) break; end
         @(posedge clock); #1;
         adma_abort = 1;
      end
      for (int i = 0; i < 20000; i++) begin
         @(negedge clock);
         if (!busy || adma_err_int) begin fin = 1; break; end
      end
      repeat (3) @(negedge clock);
      adma_abort = 0;
      chk("walk_end", {63'd0, fin}, 64'd1);
      chk("err_int", {63'd0, adma_err_int}, {63'd0, exp_err_int});
      chk("err_state", {62'd0, adma_err_state}, {62'd0, exp_err_state});
      chk("sys_addr", {32'd0, adma_sys_addr}, {32'd0, exp_sys_addr});
      chk("done_cnt", 64'(done_cnt - done0), {63'd0, exp_done});
      chk("int_cnt", 64'(int_cnt - int0), 64'(exp_int));
      chk("fetch_left", 64'(exp_fetch_q.size()), 64'd0);
      chk("xfer_left", 64'(exp_xfer_q.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] base, a, tgt;
      int n, cnt;
      reset = 1; adma_start = 0; adma_abort = 0; desc_base_addr = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_outs", {14'd0, axi_arvalid, axi_rready, xfer_start, adma_err_int, adma_done,
                       desc_int, busy, xfer_len, adma_err_state, axi_araddr[23:0]}, 64'd0);
      chk("rst_addrs", {adma_sys_addr, xfer_addr}, 64'd0);
      chk("rst_arlen", {56'd0, axi_arlen}, 64'd1);
      @(posedge clock); #1;
      reset = 0;

      // two TRANs, second is end with length 0 (64 KiB)
      mem.delete(); dma_delay = 50;
      put(32'h1000_0000, mk(16'h0200, 2'b10, 0, 0, 1), 32'h2000_0000);
      put(32'h1000_0008, mk(16'h0000, 2'b10, 0, 1, 1), 32'h2001_0000);
      run_walk(32'h1000_0000, -1, 0);
      dma_delay = -1;

      // LINK then TRAN end
      mem.delete();
      put(32'h1000_0000, mk(16'h0000, 2'b11, 0, 0, 1), 32'h1800_0000);
      put(32'h1800_0000, mk(16'h0040, 2'b10, 0, 1, 1), 32'h2200_0000);
      run_walk(32'h1000_0000, -1, 0);

      // invalid first descriptor
      mem.delete();
      put(32'h1000_0000, mk(16'h0010, 2'b10, 0, 1, 0), 32'h2300_0000);
      run_walk(32'h1000_0000, -1, 0);

      // DMA error on the second segment
      mem.delete();
      put(32'h1000_0000, mk(16'h0100, 2'b10, 0, 0, 1), 32'h2400_0000);
      put(32'h1000_0008, mk(16'h0080, 2'b10, 0, 1, 1), 32'h2500_0000);
      run_walk(32'h1000_0000, 1, 0);

      // fetch timeout: arready never rises
      mem.delete(); exp_fetch_q.delete(); exp_xfer_q.delete();
      ar_block = 1;
      @(posedge clock); #1;
      desc_base_addr = 32'h1000_0000; adma_start = 1;
      @(posedge clock); #1;
      adma_start = 0;
      cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (axi_arvalid) cnt++;
         if (adma_err_int) break;
      end
      chk("tmo_cycles", 64'(cnt), 64'd1024);
      chk("tmo_err_int", {63'd0, adma_err_int}, 64'd1);
      chk("tmo_err_state", {62'd0, adma_err_state}, 64'd1);
      chk("tmo_sys_addr", {32'd0, adma_sys_addr}, 64'h1000_0000);
      ar_block = 0;

      // seventeen NOPs trip the loop guard
      mem.delete();
      for (int i = 0; i < 17; i++) put(32'h1000_0000 + 32'(i * 8), mk(16'h0, 2'b00, 0, 0, 1), 32'h0);
      run_walk(32'h1000_0000, -1, 0);

      // interrupt-flagged end TRAN
      mem.delete();
      put(32'h1000_0000, mk(16'h0020, 2'b10, 1, 1, 1), 32'h2600_0000);
      run_walk(32'h1000_0000, -1, 0);

      // misaligned base
      mem.delete();
      run_walk(32'h1000_0004, -1, 0);

      // abort held during the transfer
      mem.delete();
      put(32'h1000_0000, mk(16'h0030, 2'b10, 1, 1, 1), 32'h2700_0000);
      run_walk(32'h1000_0000, -1, 1);

      // randomized tables
      for (int t = 0; t < 25; t++) begin
         mem.delete();
         base = 32'h1000_0000 + (32'($urandom_range(0, 4095)) << 3);
         n = $urandom_range(1, 6);
         a = base;
         for (int i = 0; i < n; i++) begin
            n = n;
            if (i == n - 1 || $urandom_range(0, 9) < 6) begin
               put(a, mk(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 2'b10,
                         1'($urandom_range(0, 1)), i == n - 1, $urandom_range(0, 19) != 0),
                   $urandom);
               a = a + 32'd8;
            end else if ($urandom_range(0, 1) == 0) begin
               put(a, mk(16'($urandom), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1), $urandom);
               a = a + 32'd8;
            end else begin
               tgt = 32'h4000_0000 + (32'(i) << 16) + (32'($urandom_range(0, 255)) << 3);
               put(a, mk(16'($urandom), 2'b11, 1'($urandom_range(0, 1)), 0, 1), tgt);
               a = tgt;
            end
         end
         run_walk(base, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
